logic_eval_arbiter: RTL and testbench
=====================================

Name: logic_eval_arbiter

Overview:
- Shares a single 4-input pattern-match logic function (out = 1 only when the input vector equals 4'b1100) between NREQ requesters.
- Each requester submits a 4-bit vector over a valid/ready handshake. The block arbitrates round-robin, evaluates the vector through one shared decoder instance, and returns a tagged 1-bit result on a response handshake.
- Sits between the requesting control blocks and the combinational logic cell, so only one copy of the cell is instantiated.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, width of each request vector.
- MATCH, 4'b1100, vector value that evaluates to 1; every other value evaluates to 0.
- IDW, 2, width of the requester index (must equal clog2(NREQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  per-requester request valid; bit i belongs to requester i.
- req_data  input  NREQ*WIDTH  packed vectors; slice [i*WIDTH +: WIDTH] belongs to requester i.
- req_ready  output  NREQ  one-hot accept strobe; bit i high means requester i's vector is captured this cycle.
- rsp_valid  output  1  result available.
- rsp_id  output  IDW  index of the requester the result belongs to.
- rsp_match  output  1  evaluation result (1 when captured vector == MATCH).
- rsp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst. While rst=1 at a clk edge:
  - state <= IDLE, rr_ptr <= 0.
  - rsp_valid, rsp_id, rsp_match and the captured-data register all <= 0.
  - req_ready = 0 during reset.
- FSM has three states: IDLE, EVAL, RESP.
- IDLE:
  - req_ready is combinational: one-hot of the first asserted req_valid bit, searching upward from rr_ptr and wrapping from NREQ-1 to 0.
  - If any req_valid is high, capture the granted slice into data_q and the granted index into id_q at the edge, then go to EVAL.
  - If no req_valid is high, req_ready = 0 and the block stays in IDLE.
- EVAL:
  - data_q drives the shared decoder; its output is registered into rsp_match.
  - rsp_id <= id_q, rsp_valid <= 1, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_match are held stable until the handshake.
  - When rsp_valid && rsp_ready: rsp_valid <= 0, rr_ptr <= (id_q + 1) mod NREQ, go to IDLE.
  - req_ready = 0.
- Latency: accept at edge N (req_ready high in cycle N); rsp_valid high from cycle N+2. Minimum initiation interval is 3 cycles with rsp_ready tied high.
- Requester rules:
  - Must hold req_valid and req_data stable until its req_ready bit is seen.
  - Deasserting req_valid before grant is legal (request withdrawn).
  - Changes to req_valid or req_data after capture have no effect on the pending result.
- Fairness: the requester granted last has lowest priority next time. With all NREQ requesters continuously valid, grant order is 0,1,2,3,0,...
- rr_ptr advances only on response handshake, never on grant alone.
- Back-pressure: rsp_ready may be held low indefinitely; no new grant is issued while in RESP.
- rsp_ready high in the same cycle rsp_valid first rises completes the handshake in that cycle.
- Reset mid-operation: the in-flight request and response are discarded, no rsp is produced for them, and rr_ptr returns to 0.
- Width rules: the compare is exact over WIDTH bits; X/Z inputs are not supported.
- Illegal parameters (NREQ > 2**IDW) are flagged by an elaboration-time check.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, EVAL=2'd1, RESP=2'd2) and the default MATCH constant 4'b1100.
- One natural sub-module, pattern_match_cell:
  - Purely combinational, input WIDTH bits, output 1 bit, high only when in == MATCH.
  - Instantiated once and fed from data_q.
- The round-robin priority pick stays in the top level as a function (rotate, find-first-set, rotate back).

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_id=0, rsp_match=0; after release, first grant goes to requester 0.
- Single request: req_valid=4'b0100, slice 2 = 4'b1100, rsp_ready=1 -> req_ready=4'b0100 in cycle N; rsp_valid=1, rsp_id=2, rsp_match=1 in cycle N+2; back to IDLE at N+3.
- Non-match values: sweep requester 1 through all 16 vectors -> rsp_match=1 only for 4'b1100, 0 for the other 15 (including 4'b0100 and 4'b1000).
- Round-robin: all four valid continuously, slices {1100,0000,1100,1111}, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 with rsp_match 1,0,1,0,1; grants spaced exactly 3 cycles apart.
- Back-pressure: rsp_ready=0 for 10 cycles during RESP -> rsp_valid, rsp_id and rsp_match stable, req_ready=0 throughout; on rsp_ready=1, handshake completes and the next grant follows one cycle later.
- Reset mid-flight: assert rst in EVAL -> no response emitted, rsp_valid=0 next cycle, and the next grant starts the search from requester 0.

Source files
------------

// File: rtl/logic_eval_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_eval_arbiter_pkg
// Description : Shared definitions for the logic evaluation arbiter: FSM state
//               encoding and the default pattern the shared cell matches.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_eval_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] MATCH_DEFAULT = 4'b1100;

endpackage : logic_eval_arbiter_pkg
`default_nettype wire

// File: rtl/logic_eval_arbiter_match_cell.sv
`default_nettype none
// ============================================================================
// Module      : pattern_match_cell
// Description : Combinational pattern decoder; output is high only when the
//               input vector equals MATCH exactly over WIDTH bits.
// Ports       : in_vec [WIDTH-1:0]  vector under evaluation
//               match               1 when in_vec == MATCH
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_match_cell
  import logic_eval_arbiter_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MATCH = MATCH_DEFAULT
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic             match
);

  assign match = (in_vec == MATCH);

endmodule : pattern_match_cell
`default_nettype wire

// File: rtl/logic_eval_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_eval_arbiter
// Description : Round-robin arbiter sharing one pattern_match_cell between
//               NREQ requesters. A request is captured in IDLE, evaluated in
//               EVAL, and its tagged result is offered in RESP until accepted.
// Ports       : clk                        rising-edge clock
//               rst                        synchronous active-high reset
//               req_valid [NREQ-1:0]       per-requester request valid
//               req_data  [NREQ*WIDTH-1:0] packed request vectors
//               req_ready [NREQ-1:0]       one-hot accept strobe
//               rsp_valid                  result available
//               rsp_id    [IDW-1:0]        requester index of the result
//               rsp_match                  evaluation result
//               rsp_ready                  consumer accepts the result
// Revision    : 1.0 - initial release
// ============================================================================
module logic_eval_arbiter
  import logic_eval_arbiter_pkg::*;
#(
  parameter int               NREQ  = 4,
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MATCH = MATCH_DEFAULT,
  parameter int               IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_match,
  input  logic                    rsp_ready
);

  // Elaboration-time parameter sanity check
  if (NREQ > (1 << IDW)) begin : g_bad_param
    $error("logic_eval_arbiter: NREQ (%0d) exceeds 2**IDW (%0d)", NREQ, 1 << IDW);
  end

  // Round-robin pick: rotate valid so ptr sits at bit 0, find the lowest set
  // bit, then rotate the index back. Doubling the vector makes the rotation a
  // plain part-select for any NREQ, not just powers of two.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                k_hit;
    int                idx;
    dbl   = {valid, valid};
    rot   = dbl[ptr +: NREQ];
    k_hit = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) k_hit = k;
    end
    idx = int'(ptr) + k_hit;
    if (idx >= NREQ) idx = idx - NREQ;
    return idx[IDW-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_match_q, rsp_match_d;

  logic               grant_any;
  logic [IDW-1:0]     grant_idx;
  logic [NREQ-1:0]    grant_onehot;
  logic               cell_match;
  logic [IDW-1:0]     next_ptr;

  assign grant_any    = |req_valid;
  assign grant_idx    = rr_pick(req_valid, rr_ptr_q);
  assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;

  // The granted requester drops to lowest priority once its result is taken
  assign next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  pattern_match_cell #(
    .WIDTH (WIDTH),
    .MATCH (MATCH)
  ) u_cell (
    .in_vec (data_q),
    .match  (cell_match)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_match_d = rsp_match_q;
    req_ready   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant_onehot;
          data_d    = req_data[grant_idx*WIDTH +: WIDTH];
          id_d      = grant_idx;
          state_d   = ST_EVAL;
        end
      end
      ST_EVAL: begin
        rsp_match_d = cell_match;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = next_ptr;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // No capture can happen at a reset edge, so the strobe must stay low too
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      data_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      data_q      <= data_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_match_q <= rsp_match_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_match = rsp_match_q;

endmodule : logic_eval_arbiter
`default_nettype wire

// File: tb/tb_logic_eval_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_eval_arbiter
// Description : Directed self-checking bench for logic_eval_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_eval_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_match;
  logic        rsp_ready;

  int tests_run;
  int tests_failed;

  logic [3:0] exp_rr_match [4];

  logic_eval_arbiter #(
    .NREQ  (4),
    .WIDTH (4),
    .MATCH (4'b1100),
    .IDW   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_match (rsp_match),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_rr_match[0] = 4'd1;
    exp_rr_match[1] = 4'd0;
    exp_rr_match[2] = 4'd1;
    exp_rr_match[3] = 4'd0;

    // ---------------- Reset with all requesters valid ----------------
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = {4'b1111, 4'b1100, 4'b0000, 4'b1100};
    rsp_ready = 1'b1;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_rsp_match", 32'(rsp_match), 32'h0);

    // ---------------- Round-robin, all valid ----------------
    rst = 1'b0;
    #1;
    for (int r = 0; r < 5; r++) begin
      check($sformatf("rr%0d_grant", r), 32'(req_ready), 32'(4'b0001 << (r % 4)));
      step();
      check($sformatf("rr%0d_eval_ready", r), 32'(req_ready), 32'h0);
      check($sformatf("rr%0d_eval_valid", r), 32'(rsp_valid), 32'h0);
      step();
      check($sformatf("rr%0d_rsp_valid", r), 32'(rsp_valid), 32'h1);
      check($sformatf("rr%0d_rsp_id", r),    32'(rsp_id),    32'(r % 4));
      check($sformatf("rr%0d_rsp_match", r), 32'(rsp_match), 32'(exp_rr_match[r % 4]));
      check($sformatf("rr%0d_resp_ready", r), 32'(req_ready), 32'h0);
      step();
    end
    // rr pointer now 1

    // ---------------- Idle with nothing valid ----------------
    req_valid = 4'b0000;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'h0);
    step();
    check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    check("idle_req_ready2", 32'(req_ready), 32'h0);

    // ---------------- Single request on requester 2 ----------------
    req_valid = 4'b0100;
    req_data  = {4'b0000, 4'b1100, 4'b0000, 4'b0000};
    #1;
    check("single_grant", 32'(req_ready), 32'h4);
    step();
    // post-capture changes must not affect the pending result
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    step();
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id",    32'(rsp_id),    32'h2);
    check("single_rsp_match", 32'(rsp_match), 32'h1);
    step();
    check("single_idle_valid", 32'(rsp_valid), 32'h0);
    // rr pointer now 3

    // ---------------- Sweep requester 1 over all 16 vectors ----------------
    for (int v = 0; v < 16; v++) begin
      req_valid = 4'b0010;
      req_data  = 16'(v) << 4;
      #1;
      check($sformatf("sweep%0d_grant", v), 32'(req_ready), 32'h2);
      step();
      req_valid = 4'b0000;
      step();
      check($sformatf("sweep%0d_id", v),    32'(rsp_id),    32'h1);
      check($sformatf("sweep%0d_match", v), 32'(rsp_match), (v == 12) ? 32'h1 : 32'h0);
      step();
    end
    // rr pointer now 2

    // ---------------- Back-pressure on requester 3 ----------------
    req_valid = 4'b1000;
    req_data  = {4'b1100, 4'b0000, 4'b0000, 4'b1100};
    rsp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b1111;
    step();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'h1);
      check($sformatf("bp%0d_id", c),    32'(rsp_id),    32'h3);
      check($sformatf("bp%0d_match", c), 32'(rsp_match), 32'h1);
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 32'h1);
    check("bp_release_ready", 32'(req_ready), 32'h0);
    step();
    // handshake done, pointer wrapped from 3 to 0
    check("bp_after_valid", 32'(rsp_valid), 32'h0);
    check("bp_next_grant",  32'(req_ready), 32'h1);
    step();
    step();
    check("bp_next_id",    32'(rsp_id),    32'h0);
    check("bp_next_match", 32'(rsp_match), 32'h1);
    step();
    // rr pointer now 1
    check("pre_rst_grant", 32'(req_ready), 32'h2);

    // ---------------- Reset while in EVAL ----------------
    step();
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    step();
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_id",    32'(rsp_id),    32'h0);
    check("midrst_rsp_match", 32'(rsp_match), 32'h0);
    rst = 1'b0;
    #1;
    check("midrst_grant", 32'(req_ready), 32'h1);
    step();
    check("midrst_eval_valid", 32'(rsp_valid), 32'h0);
    step();
    check("midrst_rsp_valid2", 32'(rsp_valid), 32'h1);
    check("midrst_rsp_id2",    32'(rsp_id),    32'h0);
    check("midrst_rsp_match2", 32'(rsp_match), 32'h1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_logic_eval_arbiter
`default_nettype wire
